// File: rtl/pipe_pkg.sv
// Shared stage-state encoding and parameter limits for elastic_pipe_reg.
package pipe_pkg;

    localparam int MAX_STAGES = 8;
    localparam int MAX_WIDTH  = 256;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic stage. With ELASTIC_PIPE_SKID_EN: main + skid entry and a registered
// ready. Without it: a single entry whose ready passes downstream ready through.
module elastic_pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             rdy_q, rdy_d;
    logic             acc_s, drn_s;

    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign drn_s       = out_valid_o & out_ready_i;
    assign acc_s       = in_valid_i & in_ready_o & ~flush_i;

`ifdef ELASTIC_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // ready is a flop: high unless this stage is holding both entries
    assign in_ready_o = rdy_q;
    assign rdy_d      = (state_d != TWO);

    // Next state for main/skid occupancy; the skid absorbs a beat taken while stalled
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc_s) begin
                        main_d  = in_data_i;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    case ({acc_s, drn_s})
                        2'b10: begin
                            skid_d  = in_data_i;
                            state_d = TWO;
                        end
                        2'b01:   state_d = EMPTY;
                        2'b11:   main_d  = in_data_i;
                        default: state_d = ONE;
                    endcase
                end
                TWO: begin
                    if (drn_s) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Skid entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= {WIDTH{1'b0}};
        end else begin
            skid_q <= skid_d;
        end
    end
`else
    // rdy_q only holds ready low until the first edge after reset
    assign in_ready_o = rdy_q & (~out_valid_o | out_ready_i);
    assign rdy_d      = 1'b1;

    // Next state for a single-entry stage
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (acc_s) begin
            main_d  = in_data_i;
            state_d = ONE;
        end else if (drn_s) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end
`endif

    // Stage state, main entry and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= {WIDTH{1'b0}};
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Cascade of STAGES elastic stages plus an occupancy counter.
// Define ELASTIC_PIPE_SKID_EN for 2-entry stages with fully registered ready.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               in_ready,
    output logic                               out_valid,
    output logic [WIDTH-1:0]                   out_data,
    input  logic                               out_ready,
    output logic [$clog2(2*STAGES+1)-1:0]      occupancy
);

    localparam int OCC_W = $clog2(2*STAGES+1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer_s, out_xfer_s;

    for (genvar g = 0; g < STAGES; g++) begin : g_st
        logic             vin_s, rin_s, vout_s, rout_s;
        logic [WIDTH-1:0] din_s, dout_s;

        if (g == 0) begin : g_head
            assign vin_s = in_valid;
            assign din_s = in_data;
        end else begin : g_link
            assign vin_s = g_st[g-1].vout_s;
            assign din_s = g_st[g-1].dout_s;
        end

        if (g == STAGES-1) begin : g_tail
            assign rout_s = out_ready;
        end else begin : g_back
            assign rout_s = g_st[g+1].rin_s;
        end

        elastic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush),
            .in_valid_i  (vin_s),
            .in_data_i   (din_s),
            .in_ready_o  (rin_s),
            .out_valid_o (vout_s),
            .out_data_o  (dout_s),
            .out_ready_i (rout_s)
        );
    end

    assign in_ready  = g_st[0].rin_s;
    assign out_valid = g_st[STAGES-1].vout_s;
    assign out_data  = g_st[STAGES-1].dout_s;
    assign occupancy = occ_q;

    // An input offered during flush is dropped, so it never counts as accepted
    assign in_xfer_s  = in_valid & in_ready & ~flush;
    assign out_xfer_s = out_valid & out_ready;

    // Occupancy next value
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = {OCC_W{1'b0}};
        end else if (in_xfer_s & ~out_xfer_s) begin
            occ_d = occ_q + OCC_W'(1'b1);
        end else if (~in_xfer_s & out_xfer_s) begin
            occ_d = occ_q - OCC_W'(1'b1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg: stimulus pushes accepted payloads into a
// queue; a negedge monitor pops and compares every output transfer and occupancy.
module tb_elastic_pipe_reg;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
`ifdef ELASTIC_PIPE_SKID_EN
    localparam int CAP    = 2*STAGES;
    localparam bit SKID   = 1'b1;
`else
    localparam int CAP    = STAGES;
    localparam bit SKID   = 1'b0;
`endif

    logic                          clk;
    logic                          rst_n;
    logic                          flush;
    logic                          in_valid;
    logic [WIDTH-1:0]              in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic [WIDTH-1:0]              out_data;
    logic                          out_ready;
    logic [$clog2(2*STAGES+1)-1:0] occupancy;

    elastic_pipe_reg #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    logic             mon_en  = 1'b0;
    logic             lat_exact = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    int               ts_q[$];
    logic [WIDTH-1:0] mon_d;
    int               mon_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: compares occupancy/in_ready against the queue and pops on output transfers
    always @(negedge clk) begin
        if (mon_en) begin
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            if (SKID) begin
                if (exp_q.size() == CAP) chk("in_ready_full", 32'(in_ready), 32'd0);
            end else begin
                chk("in_ready", 32'(in_ready), 32'((exp_q.size() < CAP) || out_ready));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    mon_d = exp_q.pop_front();
                    mon_t = ts_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(mon_d));
                    if (lat_exact) chk("latency", 32'(cyc - mon_t), 32'(STAGES));
                    else           chk("latency_min", 32'((cyc - mon_t) >= STAGES), 32'd1);
                end
            end
        end
    end

    // One clock of stimulus, from posedge+1 to the next posedge+1
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic fl,
                         output logic acc);
        in_valid = v;
        in_data  = d;
        flush    = fl;
        @(negedge clk);
        #1;
        acc = v && in_ready && !fl;
        if (fl) begin
            exp_q.delete();
            ts_q.delete();
        end else if (acc) begin
            exp_q.push_back(d);
            ts_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        logic a;
        k = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 4*CAP + 10) begin
            cycle(1'b0, {WIDTH{1'b0}}, 1'b0, a);
            k++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, {WIDTH{1'b0}}, 1'b0, a);
        chk("drain_occ", 32'(occupancy), 32'd0);
    endtask

    task automatic fill(input int target, input logic [WIDTH-1:0] base, output int cnt);
        int k;
        logic a;
        cnt = 0;
        k = 0;
        out_ready = 1'b0;
        while (cnt < target && k < 4*CAP) begin
            cycle(1'b1, base + WIDTH'(k), 1'b0, a);
            if (a) cnt++;
            else break;
            k++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic a;
        int   cnt, n, k;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = {WIDTH{1'b0}};
        out_ready = 1'b0;

        // reset values while rst_n is low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("rel_in_ready_post", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // back-to-back with out_ready high: exact latency, one per cycle
        out_ready = 1'b1;
        lat_exact = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, WIDTH'(16'h00A0 + i), 1'b0, a);
            chk("tput_accept", 32'(a), 32'd1);
        end
        in_valid = 1'b0;
        drain();
        lat_exact = 1'b0;

        // fill with out_ready low until in_ready drops
        fill(4*CAP, 16'h00C0, cnt);
        chk("fill_count", 32'(cnt), 32'(CAP));
        chk("fill_occ",   32'(occupancy), 32'(CAP));
        drain();

        // single payload held under backpressure
        out_ready = 1'b0;
        cycle(1'b1, 16'h00A5, 1'b0, a);
        chk("stall_accept", 32'(a), 32'd1);
        k = 0;
        while (!out_valid && k < 2*STAGES + 2) begin
            cycle(1'b0, {WIDTH{1'b0}}, 1'b0, a);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'h00A5);
            cycle(1'b0, {WIDTH{1'b0}}, 1'b0, a);
        end
        drain();

        // flush with 3 held and an input offered in the same cycle
        fill(3, 16'h0030, cnt);
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        cycle(1'b1, 16'h0055, 1'b1, a);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_occ",   32'(occupancy), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2*STAGES + 2; i++) cycle(1'b0, {WIDTH{1'b0}}, 1'b0, a);

        // random valid/ready with occasional flush
        n = 0;
        k = 0;
        while (n < 10000 && k < 60000) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 199) == 0), a);
            if (a) n++;
            k++;
        end
        in_valid = 1'b0;
        chk("random_payloads", 32'(n), 32'd10000);
        drain();

        // asynchronous reset with entries held
        fill(5, 16'h0070, cnt);
        chk("prerst_occ", 32'(occupancy), 32'((CAP < 5) ? CAP : 5));
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_occ",       32'(occupancy), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        exp_q.delete();
        ts_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("midrst_rel_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("midrst_rel_post", 32'(in_ready), 32'd1);
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2*STAGES + 2; i++) cycle(1'b0, {WIDTH{1'b0}}, 1'b0, a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload bit width (1..256).
REQ-002 The block SHALL have parameter STAGES, default 1, number of cascaded register stages (1..8).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 The block SHALL have port in_ready  output  1  block accepts a payload this cycle.
REQ-009 The block SHALL have port out_valid  output  1  payload available downstream.
REQ-010 The block SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 The block SHALL have port occupancy  output  $clog2(2*STAGES+1)  entries currently held.

Function
REQ-013 A transfer SHALL occur on an edge where valid and ready are both high, at either end.
REQ-014 Payloads SHALL leave in strict acceptance order; none duplicated, none dropped except by flush.
REQ-015 Each stage SHALL hold up to 2 entries (main + skid); capacity = 2*STAGES.
REQ-016 Stage-to-stage and output ready SHALL be registered; no combinational path in_ready <- out_ready.
REQ-017 Latency SHALL be STAGES cycles from input transfer to out_valid with out_ready held high.
REQ-018 Throughput SHALL be one transfer per cycle sustained while out_ready stays high.
REQ-019 out_valid SHALL not drop and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 Stage state SHALL be EMPTY, ONE (main valid), TWO (main+skid valid); EMPTY->ONE on accept, ONE->TWO on accept with downstream stalled, TWO->ONE on drain, ONE->EMPTY on drain without accept.
REQ-021 in_ready SHALL equal 1 iff the first stage is not in TWO at the start of the cycle.
REQ-022 occupancy SHALL increment on input transfer, decrement on output transfer, unchanged on both together.
REQ-023 occupancy SHALL never exceed 2*STAGES nor wrap below 0.
REQ-024 flush=1 SHALL force all stages to EMPTY and occupancy to 0 at the next edge.
REQ-025 An input offered in a flush cycle SHALL be discarded; an output transfer in a flush cycle SHALL still count as delivered.
REQ-026 Data registers SHALL only load on accept; empty-stage data content is don't-care for out_data when out_valid=0.

Reset
REQ-027 While rst_n=0: all stages EMPTY, out_valid=0, out_data=0, occupancy=0, in_ready=0.
REQ-028 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries with no partial output.

Configuration
REQ-030 Macro ELASTIC_PIPE_SKID_EN defined: behaviour per REQ-015..REQ-021 (2-entry stages, registered ready).
REQ-031 ELASTIC_PIPE_SKID_EN undefined: each stage 1 entry, capacity STAGES, in_ready = !full_stage0 | stage0_ready_downstream (combinational chain), same latency and ordering; TWO state absent.

Structure
REQ-032 Package pipe_pkg SHALL hold stage-state enum (EMPTY, ONE, TWO) and limits MAX_STAGES=8, MAX_WIDTH=256.
REQ-033 Sub-module elastic_pipe_stage (one stage, WIDTH param) SHALL be instantiated STAGES times via generate.
REQ-034 Top SHALL hold only the generate chain, flush fan-out and occupancy counter.

Verification
REQ-035 STAGES=3, out_ready=1, push 0xA0..0xA9 back-to-back -> 0xA0 out at cycle 3 after first accept, one per cycle, in order.
REQ-036 STAGES=2, out_ready=0, push until in_ready=0 -> exactly 4 accepted, occupancy=4; then out_ready=1 -> 4 payloads in order, occupancy 0.
REQ-037 STAGES=1, hold out_ready=0 with out_valid=1 for 5 cycles -> out_data unchanged, out_valid stays 1.
REQ-038 STAGES=2, occupancy=3, flush with in_valid=1 data 0x55 -> next cycle out_valid=0, occupancy=0, 0x55 never emerges.
REQ-039 Random valid/ready (50%) 10k payloads, STAGES=4 -> scoreboard exact order, occupancy matches model every cycle.
REQ-040 rst_n pulsed low with occupancy=5 -> out_valid=0, occupancy=0, in_ready=0 immediately; in_ready=1 after first edge post-release.
